// File: rtl/axil_slave_regs.sv
// AXI4-Lite responder with CTRL/DATA/SCRATCH/STATUS registers.
// Define AXIL_SLVERR_EN to answer out-of-range accesses with SLVERR.
module axil_slave_regs #(
  parameter int          ADDR_WIDTH = 32,
  parameter logic [31:0] CTRL_RST   = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] s_awaddr,
  input  logic                  s_awvalid,
  output logic                  s_awready,
  input  logic [31:0]           s_wdata,
  input  logic [3:0]            s_wstrb,
  input  logic                  s_wvalid,
  output logic                  s_wready,
  output logic [1:0]            s_bresp,
  output logic                  s_bvalid,
  input  logic                  s_bready,
  input  logic [ADDR_WIDTH-1:0] s_araddr,
  input  logic                  s_arvalid,
  output logic                  s_arready,
  output logic [31:0]           s_rdata,
  output logic [1:0]            s_rresp,
  output logic                  s_rvalid,
  input  logic                  s_rready,
  output logic [31:0]           ctrl_out,
  input  logic [31:0]           status_in
);

  localparam logic [1:0] OKAY = 2'b00;
`ifdef AXIL_SLVERR_EN
  localparam logic [1:0] ERR_RESP = 2'b10;
`else
  localparam logic [1:0] ERR_RESP = 2'b00;
`endif

  typedef enum logic { W_IDLE, W_RESP } w_state_t;
  typedef enum logic { R_IDLE, R_DATA } r_state_t;

  w_state_t w_state, w_next;
  r_state_t r_state, r_next;

  logic [31:0] ctrl_q, data_q, scratch_q;

  logic                  aw_held, w_held;
  logic [ADDR_WIDTH-1:0] aw_addr;
  logic [31:0]           w_data;
  logic [3:0]            w_strb;

  logic                  aw_hs, w_hs, ar_hs, commit;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [31:0]           wr_data;
  logic [3:0]            wr_strb;
  logic                  wr_oor, rd_oor;
  logic [31:0]           rd_val;

  function automatic logic out_of_range(
    input logic [ADDR_WIDTH-1:0] a
  );
    return (a >> 4) != '0;
  endfunction

  function automatic logic [31:0] merge(
    input logic [31:0] old,
    input logic [31:0] nw,
    input logic [3:0]  strb
  );
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++)
      if (strb[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  // Held AW/W beats take priority over live channel values.
  assign wr_addr = aw_held ? aw_addr : s_awaddr;
  assign wr_data = w_held ? w_data : s_wdata;
  assign wr_strb = w_held ? w_strb : s_wstrb;
  assign wr_oor  = out_of_range(wr_addr);
  assign rd_oor  = out_of_range(s_araddr);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      w_state <= W_IDLE;
      r_state <= R_IDLE;
    end else begin
      w_state <= w_next;
      r_state <= r_next;
    end
  end

  always_comb begin
    w_next    = w_state;
    s_awready = 1'b0;
    s_wready  = 1'b0;
    s_bvalid  = 1'b0;
    commit    = 1'b0;
    unique case (w_state)
      W_IDLE: begin
        s_awready = !aw_held;
        s_wready  = !w_held;
        if ((aw_held || (s_awvalid && !aw_held)) &&
            (w_held || (s_wvalid && !w_held))) begin
          commit = 1'b1;
          w_next = W_RESP;
        end
      end
      W_RESP: begin
        s_bvalid = 1'b1;
        if (s_bready) w_next = W_IDLE;
      end
    endcase
  end

  assign aw_hs = s_awvalid && s_awready;
  assign w_hs  = s_wvalid && s_wready;

  always_comb begin
    r_next    = r_state;
    s_arready = 1'b0;
    s_rvalid  = 1'b0;
    unique case (r_state)
      R_IDLE: begin
        s_arready = 1'b1;
        if (s_arvalid) r_next = R_DATA;
      end
      R_DATA: begin
        s_rvalid = 1'b1;
        if (s_rready) r_next = R_IDLE;
      end
    endcase
  end

  assign ar_hs = s_arvalid && s_arready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      aw_held <= 1'b0;
      w_held  <= 1'b0;
      aw_addr <= '0;
      w_data  <= '0;
      w_strb  <= '0;
    end else if (s_bvalid && s_bready) begin
      aw_held <= 1'b0;
      w_held  <= 1'b0;
    end else begin
      if (aw_hs) begin
        aw_held <= 1'b1;
        aw_addr <= s_awaddr;
      end
      if (w_hs) begin
        w_held <= 1'b1;
        w_data <= s_wdata;
        w_strb <= s_wstrb;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ctrl_q    <= CTRL_RST;
      data_q    <= '0;
      scratch_q <= '0;
      s_bresp   <= OKAY;
    end else if (commit) begin
      s_bresp <= wr_oor ? ERR_RESP : OKAY;
      if (!wr_oor) begin
        unique case (wr_addr[3:2])
          2'd0: ctrl_q    <= merge(ctrl_q, wr_data, wr_strb);
          2'd1: data_q    <= merge(data_q, wr_data, wr_strb);
          2'd2: scratch_q <= merge(scratch_q, wr_data, wr_strb);
          2'd3: ;
        endcase
      end
    end
  end

  always_comb begin
    rd_val = '0;
    unique case (s_araddr[3:2])
      2'd0: rd_val = ctrl_q;
      2'd1: rd_val = data_q;
      2'd2: rd_val = scratch_q;
      2'd3: rd_val = status_in;
    endcase
  end

  // Registers update non-blocking, so a same-edge read sees the old value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s_rdata <= '0;
      s_rresp <= OKAY;
    end else if (ar_hs) begin
      s_rdata <= rd_oor ? 32'h0 : rd_val;
      s_rresp <= rd_oor ? ERR_RESP : OKAY;
    end
  end

  assign ctrl_out = ctrl_q;

  logic unused_addr_bits;
  assign unused_addr_bits = &{1'b0, wr_addr[1:0], s_araddr[1:0]};

endmodule
